// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host write FIFO, baud tick generator and 8N1 serialiser.
// Optional even-parity bit between data and stop: `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int FIFO_W  = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr_uart,
  input  logic [DBIT-1:0] i_w_data,
  output logic            o_tx_full,
  output logic            o_tx_empty,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick,
  output logic            o_tx
);

  localparam int DEPTH = 2 ** FIFO_W;
  localparam int BW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SMAX  = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW    = $clog2(SMAX);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [FIFO_W-1:0] PONE = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t state;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wptr;
  logic [FIFO_W-1:0] rptr;
  logic [FIFO_W-1:0] wnext;
  logic [FIFO_W-1:0] rnext;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic [DBIT-1:0]   head;

  logic [BW-1:0]     cnt;
  logic              tick;

  logic [SW-1:0]     s;
  logic [NW-1:0]     n;
  logic [DBIT-1:0]   shreg;
  logic [DBIT-1:0]   shnext;
  logic              tx;
  logic              done;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign wnext  = wptr + PONE;
  assign rnext  = rptr + PONE;
  assign wr_en  = i_wr_uart & ~full;
  assign rd_en  = (state == IDLE) & ~empty;
  assign head   = mem[rptr];
  assign shnext = shreg >> 1;
  assign tick   = (state != IDLE) &&
                  (cnt == BW'(DVSR - 1));

  // FIFO storage: written only when not full
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wptr] <= i_w_data;
  end

  // FIFO pointers and registered full/empty flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          wptr  <= wnext;
          empty <= 1'b0;
          full  <= (wnext == rptr);
        end
        2'b01: begin
          rptr  <= rnext;
          full  <= 1'b0;
          empty <= (rnext == wptr);
        end
        2'b11: begin
          wptr <= wnext;
          rptr <= rnext;
        end
        default: ;
      endcase
    end
  end

  // Baud counter: parked at 0 in IDLE so the start bit is full length
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      cnt <= '0;
    else if (state == IDLE || tick)
      cnt <= '0;
    else
      cnt <= cnt + BW'(1);
  end

  // Serialiser FSM; the line value is registered with the next state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shreg <= head;
            s     <= '0;
            tx    <= 1'b0;
            state <= START;
`ifdef UART_TX_PARITY_EN
            par   <= ^head;
`endif
          end
        end
        START: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              n     <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              shreg <= shnext;
              if (n == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                tx    <= par;
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                n  <= n + NW'(1);
                tx <= shnext[0];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              s     <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_full      = full;
  assign o_tx_empty     = empty;
  assign o_tx_busy      = (state != IDLE);
  assign o_tx_done_tick = done;
  assign o_tx           = tx;

endmodule
